// File: rtl/fifo_multi_push_pkg.sv
// Shared types and constants for the multi-push FIFO front-end scheduler.
package fifo_multi_push_pkg;

  localparam int unsigned LANES  = 4;
  localparam int unsigned DATA_W = 32;

  function automatic int unsigned credit_w(input int unsigned cap);
    return $clog2(cap + 1);
  endfunction

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HOLD   = 2'd1,
    DRAIN  = 2'd2,
    IDLE_F = 2'd3
  } arb_state_e;

  // Lane payload; data is sized for the default entry width.
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
  } lane_t;

endpackage

// File: rtl/rr_compact_sel.sv
// Round-robin selector that packs up to 'limit' grants into lanes 0..count-1.
module rr_compact_sel #(
  parameter int unsigned R = 8,
  parameter int unsigned K = 4
) (
  input  logic [R-1:0]                    req,
  input  logic [$clog2(R)-1:0]            ptr,
  input  logic [$clog2(K+1)-1:0]          limit,
  output logic [R-1:0]                    ack_c,
  output logic [K-1:0][$clog2(R)-1:0]     lane_idx_c,
  output logic [K-1:0]                    lane_vld_c,
  output logic [$clog2(R)-1:0]            last_idx_c,
  output logic [$clog2(K+1)-1:0]          count_c
);

  localparam int unsigned PW   = $clog2(R);
  localparam int unsigned CNTW = $clog2(K + 1);
  localparam int unsigned IW   = $clog2(K);

  logic [PW:0]     sum;
  logic [PW-1:0]   idx;
  logic [CNTW-1:0] cnt;

  // Scan from ptr upward modulo R; lane order follows scan order.
  always_comb begin
    ack_c      = '0;
    lane_idx_c = '0;
    lane_vld_c = '0;
    last_idx_c = '0;
    cnt        = '0;
    sum        = '0;
    idx        = '0;
    for (int j = 0; j < R; j++) begin
      sum = (PW+1)'(ptr) + (PW+1)'(j);
      if (sum >= (PW+1)'(R)) begin
        sum = sum - (PW+1)'(R);
      end
      idx = PW'(sum);
      if (req[idx] && (cnt < limit)) begin
        ack_c[idx]             = 1'b1;
        lane_idx_c[IW'(cnt)]   = idx;
        lane_vld_c[IW'(cnt)]   = 1'b1;
        last_idx_c             = idx;
        cnt                    = cnt + CNTW'(1);
      end
    end
    count_c = cnt;
  end

endmodule

// File: rtl/fifo_multi_push_arb.sv
// Credit-based round-robin scheduler feeding the four push lanes of the multi-push FIFO.
module fifo_multi_push_arb
  import fifo_multi_push_pkg::*;
#(
  parameter int unsigned W = DATA_W,
  parameter int unsigned N = 8,
  parameter int unsigned R = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [R-1:0]                      req,
  input  logic [R*W-1:0]                    req_data,
  output logic [R-1:0]                      ack,
  output logic                              push_0,
  output logic                              push_1,
  output logic                              push_2,
  output logic                              push_3,
  output logic [W-1:0]                      push_0_data,
  output logic [W-1:0]                      push_1_data,
  output logic [W-1:0]                      push_2_data,
  output logic [W-1:0]                      push_3_data,
  input  logic                              pop_valid,
  input  logic                              flush_req,
  output logic                              flush_done,
  output logic [credit_w(LANES*N)-1:0]      credits_r,
  output logic                              busy_r,
  output logic                              err_r
);

  localparam int unsigned CAP = LANES * N;
  localparam int unsigned CW  = credit_w(CAP);
  localparam int unsigned PW  = $clog2(R);
  localparam int unsigned SW  = $clog2(LANES + 1);

  arb_state_e state_r, state_nxt;

  logic                        grant_en_c;
  logic                        busy_nxt;
  logic                        flush_done_nxt;
  logic [SW-1:0]               limit_c;
  logic [R-1:0]                sel_ack;
  logic [LANES-1:0][PW-1:0]    sel_idx;
  logic [LANES-1:0]            sel_vld;
  logic [PW-1:0]               sel_last;
  logic [SW-1:0]               grant_cnt;
  logic [PW-1:0]               rr_ptr;
  logic [CW-1:0]               credits_nxt;
  logic                        ovf_c;
  logic [W-1:0]                req_arr [R];
  lane_t                       lane_r [LANES];

  always_comb begin
    for (int i = 0; i < R; i++) begin
      req_arr[i] = req_data[i*W +: W];
    end
  end

  // Grant limit: four lanes or remaining credits, whichever is smaller.
  always_comb begin
    limit_c = '0;
    if (grant_en_c) begin
      limit_c = (credits_r >= CW'(LANES)) ? SW'(LANES) : SW'(credits_r);
    end
  end

  rr_compact_sel #(
    .R (R),
    .K (LANES)
  ) u_sel (
    .req        (req),
    .ptr        (rr_ptr),
    .limit      (limit_c),
    .ack_c      (sel_ack),
    .lane_idx_c (sel_idx),
    .lane_vld_c (sel_vld),
    .last_idx_c (sel_last),
    .count_c    (grant_cnt)
  );

  assign ack = sel_ack;

  // A pop with the counter already full is a protocol error and is dropped.
  always_comb begin
    ovf_c       = pop_valid && (credits_r == CW'(CAP));
    credits_nxt = credits_r - CW'(grant_cnt) + CW'(pop_valid && !ovf_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RUN;
    end else begin
      state_r <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_r;
    case (state_r)
      RUN:     if (flush_req) state_nxt = HOLD;
      HOLD:    state_nxt = DRAIN;
      DRAIN:   if (credits_nxt == CW'(CAP)) state_nxt = IDLE_F;
      IDLE_F:  if (!flush_req) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // flush_req gates grants combinationally so the request cycle itself is blocked.
  always_comb begin
    grant_en_c     = rst_n && (state_r == RUN) && !flush_req;
    busy_nxt       = (state_nxt == HOLD) || (state_nxt == DRAIN);
    flush_done_nxt = (state_r == DRAIN) && (credits_nxt == CW'(CAP));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits_r  <= CW'(CAP);
      rr_ptr     <= '0;
      flush_done <= 1'b0;
      busy_r     <= 1'b0;
      err_r      <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        lane_r[k] <= '0;
      end
    end else begin
      credits_r  <= credits_nxt;
      flush_done <= flush_done_nxt;
      busy_r     <= busy_nxt;
      if (ovf_c) begin
        err_r <= 1'b1;
      end
      if (grant_cnt != '0) begin
        rr_ptr <= (sel_last == PW'(R - 1)) ? '0 : sel_last + PW'(1);
      end
      // Idle lanes keep their last data; only the strobe drops.
      for (int k = 0; k < LANES; k++) begin
        lane_r[k].valid <= sel_vld[k];
        if (sel_vld[k]) begin
          lane_r[k].data <= DATA_W'(req_arr[sel_idx[k]]);
        end
      end
    end
  end

  assign push_0      = lane_r[0].valid;
  assign push_1      = lane_r[1].valid;
  assign push_2      = lane_r[2].valid;
  assign push_3      = lane_r[3].valid;
  assign push_0_data = W'(lane_r[0].data);
  assign push_1_data = W'(lane_r[1].data);
  assign push_2_data = W'(lane_r[2].data);
  assign push_3_data = W'(lane_r[3].data);

endmodule

// File: tb/tb_fifo_multi_push_arb.sv
// Directed bench for fifo_multi_push_arb with a lane-data scoreboard.
module tb_fifo_multi_push_arb;

  logic         clk;
  logic         rst_n;
  logic [7:0]   req;
  logic [255:0] req_data;
  logic [7:0]   ack;
  logic         push_0, push_1, push_2, push_3;
  logic [31:0]  push_0_data, push_1_data, push_2_data, push_3_data;
  logic         pop_valid;
  logic         flush_req;
  logic         flush_done;
  logic [5:0]   credits_r;
  logic         busy_r;
  logic         err_r;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];

  logic [3:0]  mon_pv;
  logic [31:0] mon_pd [4];
  logic [31:0] mon_e;
  int          done_cnt;

  fifo_multi_push_arb #(.W(32), .N(8), .R(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .push_0      (push_0),
    .push_1      (push_1),
    .push_2      (push_2),
    .push_3      (push_3),
    .push_0_data (push_0_data),
    .push_1_data (push_1_data),
    .push_2_data (push_2_data),
    .push_3_data (push_3_data),
    .pop_valid   (pop_valid),
    .flush_req   (flush_req),
    .flush_done  (flush_done),
    .credits_r   (credits_r),
    .busy_r      (busy_r),
    .err_r       (err_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [31:0] base);
    for (int i = 0; i < 8; i++) begin
      req_data[i*32 +: 32] = base + 32'(i);
    end
  endtask

  // Monitor: lanes must be packed and carry the expected data in order.
  always @(negedge clk) begin
    if (rst_n) begin
      mon_pv    = {push_3, push_2, push_1, push_0};
      mon_pd[0] = push_0_data;
      mon_pd[1] = push_1_data;
      mon_pd[2] = push_2_data;
      mon_pd[3] = push_3_data;
      if (mon_pv != 4'h0) begin
        checks++;
        if (!(mon_pv == 4'h1 || mon_pv == 4'h3 || mon_pv == 4'h7 || mon_pv == 4'hF)) begin
          errors++;
          $display("FAIL lane_packing actual=%0h required=contiguous", mon_pv);
        end
      end
      for (int k = 0; k < 4; k++) begin
        if (mon_pv[k]) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL lane_unexpected lane=%0d actual=%0h required=none", k, mon_pd[k]);
          end else begin
            mon_e = exp_q.pop_front();
            if (mon_pd[k] !== mon_e) begin
              errors++;
              $display("FAIL lane_data lane=%0d actual=%0h required=%0h", k, mon_pd[k], mon_e);
            end
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; req = '0; req_data = '0; pop_valid = 1'b0; flush_req = 1'b0;
    #12;
    chk("rst_credits", 32'(credits_r), 32'd32);
    chk("rst_push", {28'd0, push_3, push_2, push_1, push_0}, 32'd0);
    chk("rst_flags", {29'd0, flush_done, busy_r, err_r}, 32'd0);
    chk("rst_data0", push_0_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Four requesters, full grant
    set_data(32'd10); req = 8'h0F; #1;
    chk("t1_ack", 32'(ack), 32'h0F);
    exp_q.push_back(32'd10); exp_q.push_back(32'd11);
    exp_q.push_back(32'd12); exp_q.push_back(32'd13);
    step(); req = '0;
    chk("t1_credits", 32'(credits_r), 32'd28);

    // Six full-width rounds; pointer alternates 4 / 0
    for (int c = 0; c < 6; c++) begin
      set_data(32'h100 * 32'(c + 1)); req = 8'hFF; #1;
      chk("fill_ack", 32'(ack), (c % 2 == 0) ? 32'hF0 : 32'h0F);
      for (int l = 0; l < 4; l++) begin
        exp_q.push_back(32'h100 * 32'(c + 1) + ((c % 2 == 0) ? 32'd4 : 32'd0) + 32'(l));
      end
      step();
    end
    req = '0;
    chk("fill_credits", 32'(credits_r), 32'd4);
    set_data(32'h800); req = 8'h30; #1;
    chk("pre2_ack", 32'(ack), 32'h30);
    exp_q.push_back(32'h804); exp_q.push_back(32'h805);
    step(); req = '0;
    chk("pre2_credits", 32'(credits_r), 32'd2);

    // Credit-limited grant
    set_data(32'h900); req = 8'hFF; #1;
    chk("t2_ack", 32'(ack), 32'hC0);
    exp_q.push_back(32'h906); exp_q.push_back(32'h907);
    step(); req = 8'h3F;
    chk("t2_lanes", {28'd0, push_3, push_2, push_1, push_0}, 32'h3);
    chk("t2_credits", 32'(credits_r), 32'd0);
    #1;
    chk("t2_no_credit_ack", 32'(ack), 32'h00);

    // Return 8 credits, then move pointer to 6
    req = '0; pop_valid = 1'b1;
    repeat (8) step();
    pop_valid = 1'b0;
    chk("t3_pre_credits", 32'(credits_r), 32'd8);
    set_data(32'hA00); req = 8'h30; #1;
    chk("t3_pre_ack", 32'(ack), 32'h30);
    exp_q.push_back(32'hA04); exp_q.push_back(32'hA05);
    step();

    // Wrap-around grant order 6,7,0,2
    set_data(32'hB00); req = 8'hC5; #1;
    chk("t3_ack", 32'(ack), 32'hC5);
    exp_q.push_back(32'hB06); exp_q.push_back(32'hB07);
    exp_q.push_back(32'hB00); exp_q.push_back(32'hB02);
    step(); req = '0;
    chk("t3_credits", 32'(credits_r), 32'd2);

    // Grant and credit return in the same cycle
    pop_valid = 1'b1;
    repeat (3) step();
    chk("t4_pre_credits", 32'(credits_r), 32'd5);
    set_data(32'hC00); req = 8'hFF; #1;
    chk("t4_ack", 32'(ack), 32'h78);
    exp_q.push_back(32'hC03); exp_q.push_back(32'hC04);
    exp_q.push_back(32'hC05); exp_q.push_back(32'hC06);
    step(); pop_valid = 1'b0; req = '0;
    chk("t4_credits", 32'(credits_r), 32'd2);

    // Flush with 20 entries outstanding
    pop_valid = 1'b1;
    repeat (10) step();
    pop_valid = 1'b0;
    chk("t5_pre_credits", 32'(credits_r), 32'd12);
    set_data(32'hD00); req = 8'hFF; flush_req = 1'b1; #1;
    chk("t5_flush_ack", 32'(ack), 32'h00);
    step();
    chk("t5_busy", 32'(busy_r), 32'd1);
    pop_valid = 1'b1; done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      chk("t5_drain_ack", 32'(ack), 32'h00);
      step();
      if (flush_done) done_cnt++;
    end
    pop_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (flush_done) done_cnt++;
    end
    chk("t5_done_pulses", 32'(done_cnt), 32'd1);
    chk("t5_credits", 32'(credits_r), 32'd32);
    chk("t5_idle_busy", 32'(busy_r), 32'd0);
    flush_req = 1'b0; #1;
    chk("t5_idle_ack", 32'(ack), 32'h00);
    step();
    chk("t5_resume_ack", 32'(ack), 32'h87);
    exp_q.push_back(32'hD07); exp_q.push_back(32'hD00);
    exp_q.push_back(32'hD01); exp_q.push_back(32'hD02);
    step(); req = '0;
    chk("t5_resume_credits", 32'(credits_r), 32'd28);

    // Overflowing credit return
    pop_valid = 1'b1;
    repeat (4) step();
    chk("t6_full_credits", 32'(credits_r), 32'd32);
    chk("t6_err_before", 32'(err_r), 32'd0);
    step(); pop_valid = 1'b0;
    chk("t6_err", 32'(err_r), 32'd1);
    chk("t6_credits_sat", 32'(credits_r), 32'd32);

    // Asynchronous reset mid-burst
    set_data(32'hE00); req = 8'hFF; #1;
    chk("t7_ack", 32'(ack), 32'h78);
    step();
    chk("t7_push", {28'd0, push_3, push_2, push_1, push_0}, 32'hF);
    #1; rst_n = 1'b0; #1;
    chk("t7_rst_push", {28'd0, push_3, push_2, push_1, push_0}, 32'd0);
    chk("t7_rst_data", push_0_data, 32'd0);
    chk("t7_rst_credits", 32'(credits_r), 32'd32);
    chk("t7_rst_err", 32'(err_r), 32'd0);
    chk("t7_rst_ack", 32'(ack), 32'h00);
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_multi_push_arb.md
Name: fifo_multi_push_arb

Overview:
- Front-end scheduler for the 4-lane multi-push FIFO.
- Arbitrates R requesters onto the FIFO's four push lanes and grants up to 4 per cycle in round-robin order.
- Packs grants contiguously into lanes 0..k-1. The FIFO rotates its lane-to-bank mapping by popcount, so holes would corrupt ordering.
- Tracks free capacity with a credit counter instead of the late, registered full vector. Provides a flush/drain sequence.

Parameters:
- W, 32, data width per entry.
- N, 8, depth of each of the 4 FIFO banks. Total capacity CAP = 4*N.
- R, 8, number of requesters, 2..16.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- req  in  R  per-requester request. Held, with data stable, until acked.
- req_data  in  R*W  requester i data at bits [i*W +: W].
- ack  out  R  combinational grant. Requester i's entry is accepted this cycle.
- push_0..push_3  out  1 each  registered lane push strobes to the FIFO.
- push_0_data..push_3_data  out  W each  registered lane data.
- pop_valid  in  1  FIFO pop_0_valid_r. Each pulse returns one credit.
- flush_req  in  1  level. Stop granting and wait for the FIFO to drain.
- flush_done  out  1  registered, one-cycle pulse when drained.
- credits_r  out  $clog2(CAP+1)  free entries.
- busy_r  out  1  high in states HOLD and DRAIN.
- err_r  out  1  sticky credit-overflow error.

Behaviour:
- Reset values:
  - push_*, push_*_data = 0.
  - credits_r = CAP.
  - rr_ptr = 0, state = RUN.
  - flush_done = 0, busy_r = 0, err_r = 0.
- Grant limit: G = min(4, credits_r, popcount(req)), and G = 0 outside RUN.
  - Credits returned by pop_valid in the same cycle are not usable until the next cycle.
- Selection:
  - Scan requesters from rr_ptr upward, modulo R.
  - The first G asserted requesters get ack and map in scan order to lanes 0..G-1.
  - Lanes G..3 are idle.
  - Lane k always holds an older or equal-priority requester than lane k+1.
- Push latency: lane outputs are registered, so push_k and its data appear exactly one cycle after ack. Idle lanes drive push_k = 0; their data is don't-care and holds its previous value.
- Round-robin pointer: after a cycle with G > 0, rr_ptr = (index of last granted requester + 1) mod R. It is unchanged when G = 0.
- Credits: credits_next = credits_r − G + pop_valid.
  - Width is $clog2(CAP+1), with no wrap.
  - If pop_valid arrives with credits_r == CAP, credits stay CAP and err_r sets. It clears only on reset.
- Capacity guarantee: the FIFO's lane rotation spreads entries round-robin across banks, so total occupancy ≤ CAP keeps every bank ≤ N. The FIFO full_r vector is never consulted.
- State machine:
  - RUN: grants allowed. flush_req=1 → HOLD.
  - HOLD: no grants. Wait one cycle so the in-flight lane register retires, then → DRAIN.
  - DRAIN: no grants. credits_next == CAP → pulse flush_done for the following cycle and → IDLE_F.
  - IDLE_F: no grants. flush_req=0 → RUN; otherwise remain.
- Simultaneous events:
  - flush_req asserted in the same cycle as requests: grants for that cycle are suppressed (the state is checked combinationally against flush_req).
  - Grant and credit return in the same cycle: both apply.
  - R < 4 with all requesting: G = R.
- Reset mid-operation: everything returns to reset values asynchronously. Pending reqs are not acked. The FIFO must be reset in the same domain.

Decomposition:
- Package fifo_multi_push_pkg:
  - LANES = 4.
  - Credit width function clog2(CAP+1).
  - State enum {RUN, HOLD, DRAIN, IDLE_F}.
  - Lane struct {valid, data}.
- Sub-module rr_compact_sel #(R, K=4):
  - Inputs: req vector, ptr, limit.
  - Outputs: ack vector, K lane indices with valids, last-granted index.
  - Purely combinational.
  - The top level holds the FSM, credit counter, pointer and lane registers.

Test Plan:
1. Reset, then req=8'h0F with data 10..13 → ack=8'h0F in cycle 0. Next cycle push_0..3=1 with data 10,11,12,13. credits_r 32→28. rr_ptr=4.
2. All eight requesting, credits_r=2 → ack only requesters rr_ptr and rr_ptr+1. Lanes 0,1 push; push_2, push_3 = 0. credits_r=0. The next cycle with no pop_valid gives ack=0.
3. rr_ptr=6, req=8'b1100_0101 → grant order 6,7,0,2 on lanes 0..3. rr_ptr becomes 3.
4. credits_r=5, G=4 and pop_valid=1 in the same cycle → credits_r=2.
5. 20 entries outstanding, flush_req=1 → ack=0 from that cycle. After 20 pop_valid pulses, flush_done pulses once. With flush_req dropped, the FSM returns to RUN and grants resume.
6. pop_valid at credits_r=32 → err_r=1, credits_r stays 32. Async rst_n low mid-burst → outputs zero immediately, credits_r=32.
